// File: rtl/vproc_mem_pkg.sv
// Shared types for the vector-unit memory responder: FSM state encoding,
// response pipeline entry and the bytes-per-word shift helper.
package vproc_mem_pkg;

    // Initialisation FSM state (legacy-compatible constant encoding)
    typedef logic [0:0] mem_state_t;
    localparam mem_state_t ST_CLEAR = 1'b0;
    localparam mem_state_t ST_READY = 1'b1;

    // One in-flight response: valid slot, illegal request, write request
    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } resp_entry_t;

    // log2 of bytes per memory word; byte address >> this gives word index
    function automatic int unsigned be_shift(input int unsigned mem_w);
        return $clog2(mem_w / 8);
    endfunction

endpackage

// File: rtl/vproc_mem_resp_pipe.sv
// In-order, fixed-latency shift register of response entries. No backpressure
// exists upstream, so every stage simply advances each cycle.
module vproc_mem_resp_pipe
    import vproc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  resp_entry_t entry_i,
    output resp_entry_t entry_o
);

    resp_entry_t stage_q [DEPTH];

    // Shift every stage by one each cycle; reset empties the pipe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= entry_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign entry_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vproc_mem_responder.sv
// Memory-side responder for the vector core data interface. Range-checks each
// request, drives a single-port synchronous SRAM and returns in-order
// responses SRAM_LAT cycles later. An init FSM can zero-fill the SRAM.
// Optional response counters are built when VPROC_MEM_RESP_STATS_EN is defined.
module vproc_mem_responder
    import vproc_mem_pkg::*;
#(
    parameter int unsigned MEM_W          = 32,
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned SRAM_LAT       = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_req_i,
    input  logic [31:0]                  mem_addr_i,
    input  logic                         mem_we_i,
    input  logic [MEM_W/8-1:0]           mem_be_i,
    input  logic [MEM_W-1:0]             mem_wdata_i,
    output logic                         mem_rvalid_o,
    output logic                         mem_err_o,
    output logic [MEM_W-1:0]             mem_rdata_o,
    output logic                         sram_ce_o,
    output logic                         sram_we_o,
    output logic [MEM_W/8-1:0]           sram_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr_o,
    output logic [MEM_W-1:0]             sram_wdata_o,
    input  logic [MEM_W-1:0]             sram_rdata_i,
`ifdef VPROC_MEM_RESP_STATS_EN
    output logic [31:0]                  stat_rd_o,
    output logic [31:0]                  stat_wr_o,
    output logic [31:0]                  stat_err_o,
`endif
    output logic                         init_done_o
);

    localparam int unsigned AW         = $clog2(MEM_WORDS);
    localparam int unsigned BE_W       = MEM_W / 8;
    localparam int unsigned SHIFT      = be_shift(MEM_W);
    // 33-bit window bounds so ADDR_BASE near the top of the map cannot wrap
    localparam logic [32:0] BASE_EXT   = {1'b0, ADDR_BASE};
    localparam logic [32:0] END_EXT    = BASE_EXT + 33'(MEM_WORDS) * 33'(BE_W);
    localparam logic [31:0] ALIGN_MASK = 32'(BE_W - 1);
    localparam mem_state_t  RST_STATE  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    mem_state_t     state_q, state_d;
    logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
    logic           req_legal;
    logic [32:0]    addr_ext;
    resp_entry_t    pipe_in, pipe_out;

    // Clear walks every word once, then READY is held until reset
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(MEM_WORDS - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    // FSM state and clear counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Request legality: READY, word aligned, inside the SRAM window
    always_comb begin
        addr_ext  = {1'b0, mem_addr_i};
        req_legal = (state_q == ST_READY) &&
                    ((mem_addr_i & ALIGN_MASK) == 32'h0) &&
                    (addr_ext >= BASE_EXT) && (addr_ext < END_EXT);
    end

    // SRAM port: clear write owns it in CLEAR; otherwise legal requests pass through.
    // Gated by reset so the port is quiet while reset is held.
    always_comb begin
        sram_ce_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_be_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (rst) begin
            if (state_q == ST_CLEAR) begin
                sram_ce_o   = 1'b1;
                sram_we_o   = 1'b1;
                sram_be_o   = '1;
                sram_addr_o = clr_cnt_q;
            end else if (mem_req_i && req_legal) begin
                sram_ce_o    = 1'b1;
                sram_we_o    = mem_we_i;
                sram_be_o    = mem_be_i;
                sram_addr_o  = AW'((mem_addr_i - ADDR_BASE) >> SHIFT);
                sram_wdata_o = mem_wdata_i;
            end
        end
    end

    // Every accepted request enters the pipe, legal or not
    always_comb begin
        pipe_in.valid = mem_req_i;
        pipe_in.err   = ~req_legal;
        pipe_in.we    = mem_we_i;
    end

    vproc_mem_resp_pipe #(
        .DEPTH   (SRAM_LAT)
    ) u_resp_pipe (
        .clk     (clk),
        .rst     (rst),
        .entry_i (pipe_in),
        .entry_o (pipe_out)
    );

    // Response: err and rdata are forced to 0 outside valid read slots
    always_comb begin
        mem_rvalid_o = pipe_out.valid;
        mem_err_o    = pipe_out.valid & pipe_out.err;
        mem_rdata_o  = '0;
        if (pipe_out.valid && !pipe_out.err && !pipe_out.we) begin
            mem_rdata_o = sram_rdata_i;
        end
    end

    assign init_done_o = rst && (state_q == ST_READY);

`ifdef VPROC_MEM_RESP_STATS_EN
    logic [31:0] stat_rd_q, stat_wr_q, stat_err_q;

    // Saturating counts of issued responses by kind
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
        end else if (pipe_out.valid) begin
            if (pipe_out.err) begin
                if (stat_err_q != 32'hFFFF_FFFF) stat_err_q <= stat_err_q + 32'd1;
            end else if (pipe_out.we) begin
                if (stat_wr_q != 32'hFFFF_FFFF) stat_wr_q <= stat_wr_q + 32'd1;
            end else begin
                if (stat_rd_q != 32'hFFFF_FFFF) stat_rd_q <= stat_rd_q + 32'd1;
            end
        end
    end

    assign stat_rd_o  = stat_rd_q;
    assign stat_wr_o  = stat_wr_q;
    assign stat_err_o = stat_err_q;
`endif

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Directed bench for vproc_mem_responder: MEM_WORDS=16, SRAM_LAT=3, base 0.
module tb_vproc_mem_responder;

    localparam int unsigned LAT   = 3;
    localparam int unsigned WORDS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_wdata_i;
    logic        mem_rvalid_o;
    logic        mem_err_o;
    logic [31:0] mem_rdata_o;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [3:0]  sram_be_o;
    logic [3:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;
    logic        init_done_o;
`ifdef VPROC_MEM_RESP_STATS_EN
    logic [31:0] stat_rd_o, stat_wr_o, stat_err_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vproc_mem_responder #(
        .MEM_W          (32),
        .ADDR_BASE      (32'h0000_0000),
        .MEM_WORDS      (WORDS),
        .SRAM_LAT       (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_i    (mem_req_i),
        .mem_addr_i   (mem_addr_i),
        .mem_we_i     (mem_we_i),
        .mem_be_i     (mem_be_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_rvalid_o (mem_rvalid_o),
        .mem_err_o    (mem_err_o),
        .mem_rdata_o  (mem_rdata_o),
        .sram_ce_o    (sram_ce_o),
        .sram_we_o    (sram_we_o),
        .sram_be_o    (sram_be_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i),
`ifdef VPROC_MEM_RESP_STATS_EN
        .stat_rd_o    (stat_rd_o),
        .stat_wr_o    (stat_wr_o),
        .stat_err_o   (stat_err_o),
`endif
        .init_done_o  (init_done_o)
    );

    // SRAM model: byte-masked writes, LAT-cycle read pipe; starts with junk
    logic [31:0] mem_model [WORDS] = '{default: 32'hA5A5_A5A5};
    logic [31:0] rd_pipe [LAT]     = '{default: 32'h5A5A_5A5A};

    always @(posedge clk) begin
        if (sram_ce_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be_o[b]) mem_model[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
                end
            end else begin
                rd_pipe[0] <= mem_model[sram_addr_o];
            end
        end
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign sram_rdata_i = rd_pipe[LAT-1];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_ce;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata);
        mem_req_i   = req;
        mem_addr_i  = addr;
        mem_we_i    = we;
        mem_be_i    = be;
        mem_wdata_i = wdata;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " ce"}, 32'(sram_ce_o), 32'd0);
        chk({tag, " we"}, 32'(sram_we_o), 32'd0);
        chk({tag, " be"}, 32'(sram_be_o), 32'd0);
        chk({tag, " addr"}, 32'(sram_addr_o), 32'd0);
        chk({tag, " wdata"}, sram_wdata_o, 32'd0);
        chk({tag, " rvalid"}, 32'(mem_rvalid_o), 32'd0);
        chk({tag, " err"}, 32'(mem_err_o), 32'd0);
        chk({tag, " rdata"}, mem_rdata_o, 32'd0);
        chk({tag, " init_done"}, 32'(init_done_o), 32'd0);
`ifdef VPROC_MEM_RESP_STATS_EN
        chk({tag, " stat_rd"}, stat_rd_o, 32'd0);
        chk({tag, " stat_wr"}, stat_wr_o, 32'd0);
        chk({tag, " stat_err"}, stat_err_o, 32'd0);
`endif
    endtask

    // Full clear after reset release; caller is in the first post-reset cycle
    task automatic run_clear(input int req_at);
        for (int i = 0; i < WORDS; i++) begin
            if (i == req_at) drive(1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
            if (i == req_at + 1) drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            #2;
            chk($sformatf("clr%0d ce", i), 32'(sram_ce_o), 32'd1);
            chk($sformatf("clr%0d we", i), 32'(sram_we_o), 32'd1);
            chk($sformatf("clr%0d be", i), 32'(sram_be_o), 32'hF);
            chk($sformatf("clr%0d addr", i), 32'(sram_addr_o), 32'(i));
            chk($sformatf("clr%0d wdata", i), sram_wdata_o, 32'd0);
            chk($sformatf("clr%0d init_done", i), 32'(init_done_o), 32'd0);
            if (req_at >= 0 && i == req_at + LAT) begin
                chk("clr req rvalid", 32'(mem_rvalid_o), 32'd1);
                chk("clr req err", 32'(mem_err_o), 32'd1);
                chk("clr req rdata", mem_rdata_o, 32'd0);
            end else begin
                chk($sformatf("clr%0d rvalid", i), 32'(mem_rvalid_o), 32'd0);
            end
            step();
        end
        #2;
        chk("ready init_done", 32'(init_done_o), 32'd1);
        chk("ready ce", 32'(sram_ce_o), 32'd0);
        step();
    endtask

    // One isolated request; checks SRAM drive, silent gap and the response
    task automatic run_vec(input int idx, input vec_t v);
        drive(1'b1, v.addr, v.we, v.be, v.wdata);
        #2;
        chk($sformatf("v%0d ce", idx), 32'(sram_ce_o), 32'(v.exp_ce));
        if (v.exp_ce) begin
            chk($sformatf("v%0d sram_addr", idx), 32'(sram_addr_o), 32'(v.addr[5:2]));
            chk($sformatf("v%0d sram_we", idx), 32'(sram_we_o), 32'(v.we));
            chk($sformatf("v%0d sram_be", idx), 32'(sram_be_o), 32'(v.be));
            chk($sformatf("v%0d sram_wdata", idx), sram_wdata_o, v.wdata);
        end
        step();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        for (int k = 1; k < LAT; k++) begin
            #2;
            chk($sformatf("v%0d early rvalid", idx), 32'(mem_rvalid_o), 32'd0);
            chk($sformatf("v%0d idle rdata", idx), mem_rdata_o, 32'd0);
            step();
        end
        #2;
        chk($sformatf("v%0d rvalid", idx), 32'(mem_rvalid_o), 32'd1);
        chk($sformatf("v%0d err", idx), 32'(mem_err_o), 32'(v.exp_err));
        chk($sformatf("v%0d rdata", idx), mem_rdata_o, v.exp_rdata);
        step();
    endtask

    logic [31:0] seq_addr  [4];
    logic        seq_err   [4];
    logic [31:0] seq_rdata [4];

    // Back-to-back requests (reads) in consecutive cycles; n responses follow in order
    task automatic run_burst(input string tag, input int n);
        for (int c = 0; c < n + LAT + 1; c++) begin
            if (c < n) drive(1'b1, seq_addr[c], 1'b0, 4'hF, 32'h0);
            else       drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            #2;
            if (c < n) chk($sformatf("%s%0d ce", tag, c), 32'(sram_ce_o), 32'(!seq_err[c]));
            if (c >= LAT && c < n + LAT) begin
                chk($sformatf("%s%0d rvalid", tag, c), 32'(mem_rvalid_o), 32'd1);
                chk($sformatf("%s%0d err", tag, c), 32'(mem_err_o), 32'(seq_err[c-LAT]));
                chk($sformatf("%s%0d rdata", tag, c), mem_rdata_o, seq_rdata[c-LAT]);
            end else begin
                chk($sformatf("%s%0d rvalid", tag, c), 32'(mem_rvalid_o), 32'd0);
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            addr           we    be     wdata          ce    err   rdata
        vecs[0]  = '{32'h0000_0000, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0008, 1'b1, 4'h5, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2]  = '{32'h0000_0008, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 32'h00AD_00EF};
        vecs[3]  = '{32'h0000_0004, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000};
        vecs[4]  = '{32'h0000_0004, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
        vecs[5]  = '{32'h0000_0006, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
        vecs[6]  = '{32'h0000_0040, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
        vecs[7]  = '{32'h0000_003C, 1'b1, 4'hC, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0000};
        vecs[8]  = '{32'h0000_003C, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 32'hCAFE_0000};
        vecs[9]  = '{32'h0000_000C, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000};
        vecs[10] = '{32'h0000_000C, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0000};
        vecs[11] = '{32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
        vecs[12] = '{32'h0000_0044, 1'b1, 4'hF, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_0000};

        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (3) step();
        #2;
        chk_quiet("rst");
        step();
        rst = 1'b1;

        // Clear with an illegal read of 0x10 in clear cycle 2
        run_clear(2);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Misaligned, out of range, then legal read: responses in order
        seq_addr[0] = 32'h6;  seq_err[0] = 1'b1; seq_rdata[0] = 32'h0;
        seq_addr[1] = 32'h40; seq_err[1] = 1'b1; seq_rdata[1] = 32'h0;
        seq_addr[2] = 32'h8;  seq_err[2] = 1'b0; seq_rdata[2] = 32'h00AD_00EF;
        run_burst("errseq", 3);

        // Four back-to-back reads
        seq_addr[0] = 32'h0; seq_err[0] = 1'b0; seq_rdata[0] = 32'h0;
        seq_addr[1] = 32'h4; seq_err[1] = 1'b0; seq_rdata[1] = 32'h1234_5678;
        seq_addr[2] = 32'h8; seq_err[2] = 1'b0; seq_rdata[2] = 32'h00AD_00EF;
        seq_addr[3] = 32'hC; seq_err[3] = 1'b0; seq_rdata[3] = 32'h0;
        run_burst("b2b", 4);

`ifdef VPROC_MEM_RESP_STATS_EN
        chk("stat_rd", stat_rd_o, 32'd10);
        chk("stat_wr", stat_wr_o, 32'd4);
        chk("stat_err", stat_err_o, 32'd7);
`endif

        // Reset pulse, then a second reset mid-clear at counter 7
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) drive(1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
            if (i == 6) drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            #2;
            chk($sformatf("mid%0d addr", i), 32'(sram_addr_o), 32'(i));
            if (i < 7) step();
        end
        rst = 1'b0;
        #1;
        chk_quiet("midrst");
        step();
        step();
        rst = 1'b1;
        // Flushed response from cycle 5 must not appear; clear restarts at 0
        run_clear(-1);
        vecs[0] = '{32'h0000_0008, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0};
        run_vec(100, vecs[0]);
        vecs[0] = '{32'h0000_003C, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0};
        run_vec(101, vecs[0]);
`ifdef VPROC_MEM_RESP_STATS_EN
        chk("stat_rd after", stat_rd_o, 32'd2);
        chk("stat_err after", stat_err_o, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vproc_mem_responder.md
Name: vproc_mem_responder

Overview:
Memory-side responder for the vector unit's data-memory request interface. It accepts the request channel the vector core drives (req/addr/we/be/wdata) and returns the response channel (rvalid/err/rdata) in order, with fixed latency. It fronts a single-port synchronous SRAM macro and range-checks every address. After reset, an initialisation FSM optionally zero-clears the SRAM.

Parameters:
MEM_W, 32, data width in bits; a multiple of 8.
ADDR_BASE, 32'h0000_0000, byte address of SRAM word 0.
MEM_WORDS, 1024, SRAM depth in MEM_W-bit words; a power of 2.
SRAM_LAT, 1, SRAM read latency in cycles; must be ≥1.
CLEAR_ON_RESET, 1, 1 means zero-fill the SRAM after reset; 0 means the block is ready immediately.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
mem_req_i  in  1  request valid; accepted every cycle it is high (no grant)
mem_addr_i  in  32  byte address
mem_we_i  in  1  1 = write, 0 = read
mem_be_i  in  MEM_W/8  byte enables
mem_wdata_i  in  MEM_W  write data
mem_rvalid_o  out  1  response valid, one per accepted request
mem_err_o  out  1  response error flag
mem_rdata_o  out  MEM_W  read data
sram_ce_o  out  1  SRAM chip enable
sram_we_o  out  1  SRAM write enable
sram_be_o  out  MEM_W/8  SRAM byte mask
sram_addr_o  out  $clog2(MEM_WORDS)  SRAM word index
sram_wdata_o  out  MEM_W  SRAM write data
sram_rdata_i  in  MEM_W  SRAM read data, valid SRAM_LAT cycles after ce with we=0
init_done_o  out  1  high once the FSM reaches READY

Behaviour:
- Reset values: every output is 0, the response pipeline is empty, the FSM is in CLEAR (or READY when CLEAR_ON_RESET=0), and the clear counter is 0.
- FSM CLEAR:
  - Each cycle drives ce=1, we=1, be all ones, wdata=0, addr=counter, then increments the counter.
  - Moves to READY in the cycle after writing word MEM_WORDS-1.
  - init_done_o goes high in the first READY cycle.
- FSM READY is terminal until reset. Reset asserted mid-clear restarts the clear at word 0.
- Request legality: a request is legal when all of the following hold.
  - FSM is READY.
  - addr[log2(MEM_W/8)-1:0] == 0.
  - ADDR_BASE ≤ addr < ADDR_BASE + MEM_WORDS*MEM_W/8. Compute this in 33 bits so it cannot wrap.
- SRAM drive:
  - A legal request drives the SRAM combinationally in its request cycle: ce=1, we=mem_we_i, be=mem_be_i, wdata=mem_wdata_i, and addr = (addr - ADDR_BASE) >> log2(MEM_W/8).
  - Illegal requests never touch the SRAM.
  - In CLEAR the clear write owns the port; a simultaneous request is illegal and gets err.
- Response timing:
  - A request in cycle t yields mem_rvalid_o=1 in cycle t+SRAM_LAT, exactly once, strictly in order.
  - Back-to-back requests give back-to-back responses; throughput is 1 per cycle.
- Response content:
  - err=1 iff the request was illegal.
  - rdata = sram_rdata_i for legal reads; 0 for writes and for errors.
  - mem_err_o and mem_rdata_o are 0 whenever rvalid=0.
- Write responses are also returned, with err=0 when legal.
- A write with be=0 is legal, drives ce=1 with an all-zero mask, and is acknowledged normally.
- Pipeline: an SRAM_LAT-deep shift register of {valid, err, we}. It needs no full/empty handling because there is no backpressure.

Optional Feature:
Macro VPROC_MEM_RESP_STATS_EN.
- When defined, three extra outputs exist: stat_rd_o [31:0], stat_wr_o [31:0] and stat_err_o [31:0].
  - These count responses issued as legal reads, legal writes and errors.
  - Each counter increments in its rvalid cycle, saturates at 32'hFFFF_FFFF, and resets to 0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package vproc_mem_pkg holds:
  - the state enum (CLEAR, READY);
  - the struct resp_entry_t {valid, err, we};
  - a helper function for the bytes-per-word shift amount.
- Sub-module vproc_mem_resp_pipe is the parameterised SRAM_LAT-deep in-order shift register of resp_entry_t.

Test Plan:
- Reset deassert with MEM_WORDS=16, CLEAR_ON_RESET=1: 16 writes of 0 to addr 0..15 with be=4'hF; init_done_o rises in cycle 17; a read of 0x0 returns rdata=0, err=0.
- Read at 0x10 during CLEAR: no SRAM ce from the request; rvalid with err=1 and rdata=0 after SRAM_LAT cycles.
- Write 0xDEADBEEF to 0x8 with be=4'b0101, then read 0x8: read returns 0x00AD00EF, err=0, rvalid exactly SRAM_LAT cycles after the read request.
- Misaligned 0x6 and out-of-range ADDR_BASE+64 (MEM_WORDS=16): both give err=1, sram_ce_o stays 0, and two consecutive rvalids are returned in order.
- With SRAM_LAT=3, four back-to-back reads of 0x0, 0x4, 0x8, 0xC: four consecutive rvalids in cycles t+3..t+6 with matching data.
- Reset pulse mid-CLEAR at counter=7: outputs go to 0 immediately; the clear restarts at word 0; with the stats macro defined, all counters read 0.
